// File: rtl/crush_chg_pkg.sv
// crush_chg_pkg: shared state encoding and default sizes for the change-ack responder.
package crush_chg_pkg;
  typedef enum logic {CHG_IDLE, CHG_ACK} chg_state_e;
  localparam int CHG_WIDTH = 32;
  localparam int CHG_DEPTH = 4;
  localparam int CHG_TS_WIDTH = 32;
endpackage

// File: rtl/chg_fifo.sv
// chg_fifo: first-word-fall-through circular buffer with push, pop, full, empty and count.
module chg_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_count = r_count;
  // Head reads as zero when empty so the output is defined straight out of reset.
  assign o_data = o_empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/change_ack_responder.sv
// change_ack_responder: captures the monitored register on each change request and holds ack until release.
// Optional CHG_TIMESTAMP_EN stores a free-running cycle timestamp with each entry.
module change_ack_responder
  import crush_chg_pkg::*;
#(
  parameter int WIDTH = CHG_WIDTH,
  parameter int DEPTH = CHG_DEPTH,
  parameter int TS_WIDTH = CHG_TS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     chg,
  input  logic [WIDTH-1:0]         register,
  output logic                     ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
`ifdef CHG_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]      out_ts,
`endif
  output logic [$clog2(DEPTH):0]   fifo_count
);
`ifdef CHG_TIMESTAMP_EN
  localparam int DW = WIDTH + TS_WIDTH;
  logic [TS_WIDTH-1:0] r_ts;
`else
  localparam int DW = WIDTH;
`endif
  chg_state_e r_state;
  logic r_ack;
  logic w_full, w_empty, w_push;
  logic [DW-1:0] w_din, w_dout;
  assign w_push = r_state == CHG_IDLE && chg && !w_full;
  assign ack = r_ack;
  assign out_valid = !w_empty;
  assign out_data = w_dout[WIDTH-1:0];
`ifdef CHG_TIMESTAMP_EN
  assign w_din = {r_ts, register};
  assign out_ts = w_dout[DW-1:WIDTH];
  always_ff @(posedge clk)
    r_ts <= rst ? '0 : r_ts + 1'b1;
`else
  assign w_din = register;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CHG_IDLE;
      r_ack <= 1'b0;
    end else if (r_state == CHG_IDLE) begin
      if (w_push) begin
        r_state <= CHG_ACK;
        r_ack <= 1'b1;
      end
    end else if (!chg) begin
      r_state <= CHG_IDLE;
      r_ack <= 1'b0;
    end
  end
  chg_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_pop(out_ready),
    .i_data(w_din),
    .o_data(w_dout),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(fifo_count)
  );
endmodule

// File: tb/tb_change_ack_responder.sv
// tb_change_ack_responder: directed self-checking bench for change_ack_responder.
module tb_change_ack_responder;
  logic clk = 0, rst = 1, chg = 0, out_ready = 0;
  logic ack, out_valid;
  logic [31:0] register = 0, out_data;
  logic [2:0] fifo_count;
`ifdef CHG_TIMESTAMP_EN
  logic [31:0] out_ts;
`endif
  int checks = 0, failures = 0;
  int tb_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= rst ? 0 : tb_cyc + 1;

  change_ack_responder #(.WIDTH(32), .DEPTH(4), .TS_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .chg(chg),
    .register(register),
    .ack(ack),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
`ifdef CHG_TIMESTAMP_EN
    .out_ts(out_ts),
`endif
    .fifo_count(fifo_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    chg = 0;
    out_ready = 0;
    step();
    step();
    rst = 0;
  endtask

  task automatic do_change(input logic [31:0] v);
    int n;
    register = v;
    chg = 1;
    n = 0;
    do begin
      step();
      n++;
    end while (!ack && n < 20);
    checks++;
    if (ack !== 1'b1) begin
      failures++;
      $display("FAIL change_ack v=%h got ack=%b want 1", v, ack);
    end
    step();
    chg = 0;
    step();
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL change_release v=%h got ack=%b want 0", v, ack);
    end
  endtask

  task automatic pop_check(input logic [31:0] v);
    checks++;
    if (out_valid !== 1'b1 || out_data !== v) begin
      failures++;
      $display("FAIL pop got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, v);
    end
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ack !== 1'b0 || out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL reset got ack=%b valid=%b count=%0d want 0 0 0", ack, out_valid, fifo_count);
    end
`ifdef CHG_TIMESTAMP_EN
    checks++;
    if (out_ts !== 32'd0) begin
      failures++;
      $display("FAIL reset_ts got %0d want 0", out_ts);
    end
`endif
  endtask

  task automatic test_single();
    do_reset();
    register = 32'hA5A5_0001;
    chg = 1;
    step();
    checks++;
    if (ack !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL single_e0 got ack=%b valid=%b data=%h count=%0d want 1 1 a5a50001 1", ack, out_valid, out_data, fifo_count);
    end
    register = 32'hDEAD_BEEF;
    step();
    chg = 0;
    checks++;
    if (ack !== 1'b1 || fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL single_e1 got ack=%b count=%0d want 1 1", ack, fifo_count);
    end
    step();
    checks++;
    if (ack !== 1'b0 || fifo_count !== 3'd1 || out_data !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL single_e2 got ack=%b count=%0d data=%h want 0 1 a5a50001", ack, fifo_count, out_data);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= 4; i++) do_change(32'(i));
    register = 5;
    chg = 1;
    step();
    step();
    checks++;
    if (ack !== 1'b0 || fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL fill_full got ack=%b count=%0d want 0 4", ack, fifo_count);
    end
    pop_check(1);
    checks++;
    if (ack !== 1'b0 || fifo_count !== 3'd3) begin
      failures++;
      $display("FAIL fill_pop_edge got ack=%b count=%0d want 0 3", ack, fifo_count);
    end
    step();
    checks++;
    if (ack !== 1'b1 || fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL fill_late_push got ack=%b count=%0d want 1 4", ack, fifo_count);
    end
    step();
    chg = 0;
    step();
    for (int i = 2; i <= 5; i++) pop_check(32'(i));
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL fill_drained got valid=%b count=%0d want 0 0", out_valid, fifo_count);
    end
  endtask

  task automatic test_simul();
    do_reset();
    do_change(11);
    do_change(22);
    register = 33;
    chg = 1;
    out_ready = 1;
    step();
    out_ready = 0;
    checks++;
    if (fifo_count !== 3'd2 || out_data !== 32'd22 || ack !== 1'b1) begin
      failures++;
      $display("FAIL simul got count=%0d data=%0d ack=%b want 2 22 1", fifo_count, out_data, ack);
    end
    step();
    chg = 0;
    step();
    pop_check(22);
    pop_check(33);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_change(32'(100 + i));
      checks++;
      if (fifo_count > 3'd4) begin
        failures++;
        $display("FAIL wrap_count got %0d want <=4", fifo_count);
      end
      if (i >= 2) pop_check(32'(98 + i));
    end
    pop_check(108);
    pop_check(109);
  endtask

  task automatic test_reset_mid();
    do_reset();
    do_change(1);
    do_change(2);
    register = 3;
    chg = 1;
    step();
    checks++;
    if (ack !== 1'b1 || fifo_count !== 3'd3) begin
      failures++;
      $display("FAIL mid_pre got ack=%b count=%0d want 1 3", ack, fifo_count);
    end
    rst = 1;
    register = 77;
    step();
    checks++;
    if (ack !== 1'b0 || out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset got ack=%b valid=%b count=%0d want 0 0 0", ack, out_valid, fifo_count);
    end
    rst = 0;
    step();
    checks++;
    if (ack !== 1'b1 || fifo_count !== 3'd1 || out_data !== 32'd77) begin
      failures++;
      $display("FAIL mid_recapture got ack=%b count=%0d data=%0d want 1 1 77", ack, fifo_count, out_data);
    end
    step();
    chg = 0;
    step();
  endtask

`ifdef CHG_TIMESTAMP_EN
  task automatic test_ts();
    int n;
    do_reset();
    n = 0;
    while (tb_cyc < 10 && n < 100) begin
      step();
      n++;
    end
    do_change(32'h10);
    n = 0;
    while (tb_cyc < 25 && n < 100) begin
      step();
      n++;
    end
    do_change(32'h25);
    checks++;
    if (out_ts !== 32'd10) begin
      failures++;
      $display("FAIL ts_first got %0d want 10", out_ts);
    end
    pop_check(32'h10);
    checks++;
    if (out_ts !== 32'd25) begin
      failures++;
      $display("FAIL ts_second got %0d want 25", out_ts);
    end
    pop_check(32'h25);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_simul();
    test_wrap();
    test_reset_mid();
`ifdef CHG_TIMESTAMP_EN
    test_ts();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
